load_store_unit: RTL and testbench

- Memory stage directly downstream of the execute-stage ALU. Consumes the ALU result as the effective address and rs2 as store data.
- Drives a word-wide data-memory port that has a valid/ready request channel and a separate read-return channel.
- Performs byte-lane steering, byte enables, load sign/zero extension and misalignment detection.
- Stalls the core until each access completes.

---
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 tb/tb_load_store_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory stage: byte-lane steering, extension, misalignment, stall
`timescale 1ns/1ps
module load_store_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              misaligned,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [1:0]          off_q, off_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                misaligned_q, misaligned_d;

  logic [1:0]          req_off;
  logic                req_illegal;
  logic [3:0]          req_be;
  logic [DATA_W-1:0]   req_lane_data;
  logic [DATA_W-1:0]   rd_shifted;
  logic [DATA_W-1:0]   ld_data;

  // Decode the incoming request: legality, byte enables and replicated store data.
  always_comb begin
    req_off       = req_addr[1:0];
    req_illegal   = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_off[0]) ||
                    (req_size == 2'b10 && req_off != 2'b00);
    req_be        = 4'hF;
    req_lane_data = req_wdata;
    case (req_size)
      2'b00: begin
        req_be        = 4'b0001 << req_off;
        req_lane_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be        = 4'b0011 << req_off;
        req_lane_data = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be        = 4'hF;
        req_lane_data = req_wdata;
      end
    endcase
  end

  // Align the returned word to the accessed byte and extend to full width.
  always_comb begin
    rd_shifted = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   ld_data = {{(DATA_W-8){~uns_q & rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   ld_data = {{(DATA_W-16){~uns_q & rd_shifted[15]}}, rd_shifted[15:0]};
      default: ld_data = rd_shifted;
    endcase
  end

  // Next-state logic; memory-side fields are only updated on accept so they stay stable in REQ.
  always_comb begin
    state_d      = state_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    resp_rdata_d = resp_rdata_q;
    misaligned_d = misaligned_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_illegal) begin
            misaligned_d = 1'b1;
            resp_rdata_d = '0;
            state_d      = RESP;
          end else begin
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = req_be;
            mem_wdata_d = req_lane_data;
            size_d      = req_size;
            uns_d       = req_unsigned;
            off_d       = req_off;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        // A read return coincident with the handshake is not legal and is dropped.
        if (mem_ready) begin
          if (mem_we_q) begin
            misaligned_d = 1'b0;
            state_d      = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          resp_rdata_d = ld_data;
          misaligned_d = 1'b0;
          state_d      = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'h0;
      mem_wdata_q  <= '0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      resp_rdata_q <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      resp_rdata_q <= resp_rdata_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_valid  = (state_q == REQ);
  assign resp_valid = (state_q == RESP);
  assign stall      = (state_q == REQ) || (state_q == WAIT) || (state_q == IDLE && req_valid);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_rdata = resp_rdata_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        resp_valid, misaligned, stall;
  logic [31:0] resp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .misaligned(misaligned), .stall(stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One access from IDLE; memory answers after rdy_dly wait cycles, read data rv_dly cycles after ready.
  task automatic access(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int rdy_dly, input int rv_dly, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                        input logic exp_mis, input int exp_lat);
    int  cyc;
    int  k;
    int  w;
    bit  done;
    bit  chk_rd;
    chk_rd       = !we || exp_mis;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    mem_ready    = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = rdata;
    #1;
    check({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, " stall0"}, {31'b0, stall}, 32'd1);
    cyc = 0; k = 0; w = 0; done = 0;
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      req_valid  = 1'b0;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      #1;
      if (resp_valid) begin
        done = 1;
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " misaligned"}, {31'b0, misaligned}, {31'b0, exp_mis});
        if (chk_rd) check({tag, " rdata"}, resp_rdata, exp_rdata);
        check({tag, " stall resp"}, {31'b0, stall}, 32'd0);
        check({tag, " mem_valid cycles"}, k, exp_mis ? 0 : rdy_dly + 1);
      end else if (mem_valid) begin
        check({tag, " mem_addr"}, mem_addr, exp_addr);
        check({tag, " mem_be"}, {28'b0, mem_be}, {28'b0, exp_be});
        check({tag, " mem_we"}, {31'b0, mem_we}, {31'b0, we});
        if (we) check({tag, " mem_wdata"}, mem_wdata, exp_wdata);
        check({tag, " stall req"}, {31'b0, stall}, 32'd1);
        mem_ready = (k >= rdy_dly);
        k++;
      end else begin
        w++;
        check({tag, " stall wait"}, {31'b0, stall}, 32'd1);
        if (w >= rv_dly) mem_rvalid = 1'b1;
      end
      if (!done && cyc > 30) begin
        check({tag, " timeout"}, 32'd0, 32'd1);
        done = 1;
      end
    end
    @(posedge clk); #1;
    check({tag, " resp pulse end"}, {31'b0, resp_valid}, 32'd0);
    check({tag, " idle ready"}, {31'b0, req_ready}, 32'd1);
    if (chk_rd) check({tag, " rdata hold"}, resp_rdata, exp_rdata);
  endtask

  initial begin
    reset = 1'b1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst mem_valid", {31'b0, mem_valid}, 32'd0);
    check("rst mem_we", {31'b0, mem_we}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_be", {28'b0, mem_be}, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst misaligned", {31'b0, misaligned}, 32'd0);
    check("rst req_ready", {31'b0, req_ready}, 32'd1);
    check("rst stall", {31'b0, stall}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // stray read return while idle
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("stray idle resp_valid", {31'b0, resp_valid}, 32'd0);
      check("stray idle ready", {31'b0, req_ready}, 32'd1);
    end
    mem_rvalid = 1'b0;

    //     tag           we    size   uns   addr          wdata         rdy rv rdata          exp_addr      be       exp_wdata     exp_rdata     mis  lat
    access("sb 1003",    1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0,          32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0,         1'b0, 2);
    access("sh 1002",    1'b1, 2'b01, 1'b0, 32'h0000_1002, 32'h1234_BEEF, 1, 0, 32'h0,          32'h0000_1000, 4'b1100, 32'hBEEF_BEEF, 32'h0,         1'b0, 3);
    access("sw fffffffc",1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 0, 0, 32'h0,          32'hFFFF_FFFC, 4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b0, 2);
    access("lh 2002",    1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0,         0, 1, 32'h8001_1234,  32'h0000_2000, 4'b1100, 32'h0,         32'hFFFF_8001, 1'b0, 3);
    access("lhu 2002",   1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,         0, 1, 32'h8001_1234,  32'h0000_2000, 4'b1100, 32'h0,         32'h0000_8001, 1'b0, 3);
    access("lb 2001",    1'b0, 2'b00, 1'b0, 32'h0000_2001, 32'h0,         0, 1, 32'h8001_1234,  32'h0000_2000, 4'b0010, 32'h0,         32'h0000_0012, 1'b0, 3);
    access("lb 2003",    1'b0, 2'b00, 1'b0, 32'h0000_2003, 32'h0,         0, 1, 32'h8001_1234,  32'h0000_2000, 4'b1000, 32'h0,         32'hFFFF_FF80, 1'b0, 3);
    access("lbu 2003",   1'b0, 2'b00, 1'b1, 32'h0000_2003, 32'h0,         0, 1, 32'h8001_1234,  32'h0000_2000, 4'b1000, 32'h0,         32'h0000_0080, 1'b0, 3);
    access("lw 3000",    1'b0, 2'b10, 1'b1, 32'h0000_3000, 32'h0,         3, 2, 32'h9357_9BDF,  32'h0000_3000, 4'b1111, 32'h0,         32'h9357_9BDF, 1'b0, 7);
    access("sw 4002 mis",1'b1, 2'b10, 1'b0, 32'h0000_4002, 32'h1111_2222, 0, 0, 32'h0,          32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 1);
    access("lw 3000 b",  1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0,         0, 1, 32'h0BAD_F00D,  32'h0000_3000, 4'b1111, 32'h0,         32'h0BAD_F00D, 1'b0, 3);
    access("lh 4001 mis",1'b0, 2'b01, 1'b0, 32'h0000_4001, 32'h0,         0, 0, 32'h0,          32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 1);
    access("size11",     1'b0, 2'b11, 1'b0, 32'h0000_5000, 32'h0,         0, 0, 32'h0,          32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 1);
    access("sb 6000",    1'b1, 2'b00, 1'b0, 32'h0000_6000, 32'h0000_007E, 0, 0, 32'h0,          32'h0000_6000, 4'b0001, 32'h7E7E_7E7E, 32'h0,         1'b0, 2);

    // a load that completes normally leaves resp_rdata non-zero before the abandoned access
    access("lw 7000",    1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'h0,         0, 1, 32'h7777_1111,  32'h0000_7000, 4'b1111, 32'h0,         32'h7777_1111, 1'b0, 3);

    // reset while waiting for read data, then a late return
    req_we = 1'b0; req_size = 2'b01; req_unsigned = 1'b0; req_addr = 32'h0000_3002; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rw in req", {31'b0, mem_valid}, 32'd1);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("rw in wait mem_valid", {31'b0, mem_valid}, 32'd0);
    check("rw in wait stall", {31'b0, stall}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rw req_ready", {31'b0, req_ready}, 32'd1);
    check("rw mem_be", {28'b0, mem_be}, 32'd0);
    check("rw mem_addr", mem_addr, 32'd0);
    check("rw resp_rdata", resp_rdata, 32'd0);
    check("rw stall", {31'b0, stall}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rw late rvalid resp", {31'b0, resp_valid}, 32'd0);
      check("rw late rvalid ready", {31'b0, req_ready}, 32'd1);
    end
    mem_rvalid = 1'b0;
    check("rw rdata unchanged", resp_rdata, 32'd0);

    access("sh after rst",1'b1, 2'b01, 1'b0, 32'h0000_8000, 32'h0000_C3D4, 0, 0, 32'h0,         32'h0000_8000, 4'b0011, 32'hC3D4_C3D4, 32'h0,         1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
